// File: rtl/hover_pkg.sv
// Shared types and defaults for the hover throttle controller.
package hover_pkg;

    localparam int DEF_TOP_Y     = 50;
    localparam int DEF_DEAD_Y    = 306;
    localparam int DEF_HOVER_MAX = 128;
    localparam int DEF_BASE      = 160;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        MAP
    } state_t;

    // Bits needed to encode `value` distinct states; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result = 0;
        int v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hover_ctrl_if.sv
// Frame handshake and throttle outputs between the hand tracker, the
// controller and the motor mixer.
interface hover_ctrl_if #(
    parameter int NUM_HANDS = 2,
    parameter int Y_W       = 16,
    parameter int OUT_W     = 8
);
    logic                     on;
    logic                     frame_valid;
    logic [NUM_HANDS*Y_W-1:0] y_flat;
    logic [NUM_HANDS-1:0]     hand_valid;
    logic                     busy;
    logic [OUT_W-1:0]         target;
    logic [OUT_W-1:0]         hover;
    logic                     track_lost;

    modport master (
        output on, frame_valid, y_flat, hand_valid,
        input  busy, target, hover, track_lost
    );

    modport slave (
        input  on, frame_valid, y_flat, hand_valid,
        output busy, target, hover, track_lost
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider: loads on start, then takes exactly SUM_W cycles
// and pulses done for one cycle. A zero divisor yields a zero quotient.
module seq_divider
    import hover_pkg::*;
#(
    parameter int SUM_W = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    localparam int STEP_W = clog2(SUM_W + 1);

    logic [SUM_W-1:0]  rem_q, quo_q, div_q;
    logic [STEP_W-1:0] steps_q;
    logic              zero_q, done_q;
    logic [SUM_W:0]    rem_sh, rem_sub, rem_nxt;
    logic              fits;

    // The dividend shifts out of quo_q as quotient bits shift in.
    assign rem_sh  = {rem_q, quo_q[SUM_W-1]};
    assign rem_sub = rem_sh - {1'b0, div_q};
    assign fits    = (rem_sh >= {1'b0, div_q});
    assign rem_nxt = fits ? rem_sub : rem_sh;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q   <= '0;
                quo_q   <= dividend;
                div_q   <= divisor;
                zero_q  <= (divisor == '0);
                steps_q <= STEP_W'(SUM_W);
            end else if (steps_q != '0) begin
                rem_q   <= SUM_W'(rem_nxt);
                quo_q   <= {quo_q[SUM_W-2:0], fits};
                steps_q <= steps_q - 1'b1;
                done_q  <= (steps_q == STEP_W'(1));
            end
        end
    end

    assign done     = done_q;
    assign quotient = zero_q ? '0 : quo_q;

endmodule

// File: rtl/hover_ctrl.sv
// Hover throttle controller: averages usable hand heights per frame, maps the
// average to a throttle setpoint and slew-limits the hover output toward it.
module hover_ctrl
    import hover_pkg::*;
#(
    parameter int NUM_HANDS = 2,
    parameter int Y_W       = 16,
    parameter int OUT_W     = 8,
    parameter int TOP_Y     = DEF_TOP_Y,
    parameter int DEAD_Y    = DEF_DEAD_Y,
    parameter int HOVER_MAX = DEF_HOVER_MAX,
    parameter int BASE      = DEF_BASE,
    parameter int SHIFT     = 1,
    parameter int SLEW_STEP = 4,
    parameter int SLEW_DIV  = 1000,
    parameter int TIMEOUT   = 2000000
) (
    input  logic        clock,
    input  logic        reset,
    hover_ctrl_if.slave bus
);
    localparam int SUM_W = Y_W + clog2(NUM_HANDS);
    localparam int IDX_W = (NUM_HANDS > 1) ? clog2(NUM_HANDS) : 1;
    localparam int CNT_W = clog2(NUM_HANDS + 1);
    localparam int PRE_W = (SLEW_DIV > 1) ? clog2(SLEW_DIV) : 1;
    localparam int TO_W  = clog2(TIMEOUT + 1);
    localparam int MAP_W = OUT_W + Y_W;

    state_t                   state_q, state_nxt;
    logic [NUM_HANDS*Y_W-1:0] y_q;
    logic [NUM_HANDS-1:0]     hv_q;
    logic [IDX_W-1:0]         idx_q;
    logic [SUM_W-1:0]         sum_q, sum_nxt, quotient;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic                     dead_q, lost_q;
    logic [OUT_W-1:0]         target_q, hover_q, map_value, slew_value;
    logic [OUT_W-1:0]         eff_target, gap, step;
    logic [PRE_W-1:0]         pre_q;
    logic [TO_W-1:0]          to_q;
    logic [Y_W-1:0]           cur_y;
    logic signed [MAP_W-1:0]  mapped;
    logic                     usable, last_hand, accept, tick, div_start, div_done;

    assign cur_y     = y_q[idx_q*Y_W +: Y_W];
    assign usable    = hv_q[idx_q] && (cur_y != '0);
    assign last_hand = (idx_q == IDX_W'(NUM_HANDS - 1));
    assign accept    = (state_q == IDLE) && bus.frame_valid;
    assign sum_nxt   = sum_q + (usable ? SUM_W'(cur_y) : '0);
    assign cnt_nxt   = cnt_q + CNT_W'(usable);
    assign tick      = (pre_q == PRE_W'(SLEW_DIV - 1));

    // Loaded on the last accumulate edge with the sum including the final hand.
    seq_divider #(.SUM_W(SUM_W)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_nxt),
        .divisor  (SUM_W'(cnt_nxt)),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE:    if (bus.frame_valid) state_nxt = ACCUM;
            ACCUM:   if (last_hand) begin
                         state_nxt = DIVIDE;
                         div_start = 1'b1;
                     end
            DIVIDE:  if (div_done) state_nxt = MAP;
            MAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Signed mapping so BASE - avg/2 going negative clamps instead of wrapping.
    always_comb begin
        mapped    = $signed(MAP_W'(BASE)) - $signed(MAP_W'(quotient >> SHIFT));
        map_value = '0;
        if (!bus.on || dead_q || (cnt_q == '0))             map_value = '0;
        else if (quotient < SUM_W'(TOP_Y))                  map_value = OUT_W'(HOVER_MAX);
        else if (mapped[MAP_W-1])                           map_value = '0;
        else if (mapped > $signed(MAP_W'(HOVER_MAX)))       map_value = OUT_W'(HOVER_MAX);
        else                                                map_value = OUT_W'(mapped);
    end

    // NOTE: the captured frame is reset along with the rest so an aborted frame
    // leaves nothing behind for the next one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            y_q      <= '0;
            hv_q     <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            dead_q   <= 1'b0;
            target_q <= '0;
        end else begin
            if (accept) begin
                y_q    <= bus.y_flat;
                hv_q   <= bus.hand_valid;
                idx_q  <= '0;
                sum_q  <= '0;
                cnt_q  <= '0;
                dead_q <= 1'b0;
            end else if (state_q == ACCUM) begin
                sum_q <= sum_nxt;
                cnt_q <= cnt_nxt;
                idx_q <= idx_q + 1'b1;
                if (usable && (cur_y > Y_W'(DEAD_Y))) dead_q <= 1'b1;
            end
            if (state_q == MAP) target_q <= map_value;
        end
    end

    always_comb begin
        eff_target = lost_q ? '0 : target_q;
        step       = OUT_W'(SLEW_STEP);
        gap        = '0;
        slew_value = hover_q;
        if (eff_target >= hover_q) begin
            gap        = eff_target - hover_q;
            slew_value = hover_q + ((gap > step) ? step : gap);
        end else begin
            gap        = hover_q - eff_target;
            slew_value = hover_q - ((gap > step) ? step : gap);
        end
    end

    // Disabling flight drops hover immediately, ahead of any slew step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_q   <= '0;
            hover_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (!bus.on)   hover_q <= '0;
            else if (tick) hover_q <= slew_value;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            to_q   <= '0;
            lost_q <= 1'b0;
        end else if (accept) begin
            to_q   <= '0;
            lost_q <= 1'b0;
        end else if (to_q != TO_W'(TIMEOUT)) begin
            to_q <= to_q + 1'b1;
            if (to_q == TO_W'(TIMEOUT - 1)) lost_q <= 1'b1;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.target     = target_q;
    assign bus.hover      = hover_q;
    assign bus.track_lost = lost_q;

endmodule

// File: tb/tb_hover_ctrl.sv
// Scoreboard bench for hover_ctrl: stimulus queues expected targets, a monitor
// pops them when busy falls; hover and track_lost are checked at known ticks.
module tb_hover_ctrl;
    localparam int SLEW_DIV = 16;
    localparam int TIMEOUT  = 1000;
    localparam int LAT      = 21;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   pre_m = 0;
    int   tick_count = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_acc = 0;
    logic prev_busy = 1'b0;

    logic [7:0] exp_tgt_q[$];
    int         exp_acc_q[$];
    string      exp_name_q[$];

    hover_ctrl_if #(.NUM_HANDS(2), .Y_W(16), .OUT_W(8)) bus ();

    hover_ctrl #(.SLEW_DIV(SLEW_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Slew tick reference: wraps every SLEW_DIV edges after reset release.
    always @(posedge clock) begin
        if (!reset) pre_m <= 0;
        else if (pre_m == SLEW_DIV - 1) begin
            pre_m      <= 0;
            tick_count <= tick_count + 1;
        end else pre_m <= pre_m + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: each busy fall outside reset is one target update.
    always @(negedge clock) begin
        if (!reset) prev_busy <= 1'b0;
        else begin
            if (prev_busy && !bus.busy) begin
                if (exp_tgt_q.size() == 0) begin
                    check("spurious_target_update", 0, 1);
                end else begin
                    logic [7:0] t;
                    int         a;
                    string      n;
                    t = exp_tgt_q.pop_front();
                    a = exp_acc_q.pop_front();
                    n = exp_name_q.pop_front();
                    check({n, "_target"}, bus.target, t);
                    check({n, "_latency"}, cyc - a, LAT);
                end
            end
            prev_busy <= bus.busy;
        end
    end

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n);
        int goal;
        goal = tick_count + n;
        while (tick_count < goal) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (bus.busy && guard < 2 * LAT) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check({name, "_done"}, bus.busy, 0);
    endtask

    task automatic send(input logic [15:0] y0, input logic [15:0] y1, input logic [1:0] hv,
                        input logic [7:0] tgt, input bit push, input string name);
        int guard = 0;
        while (bus.busy && guard < 2 * LAT) begin
            @(posedge clock);
            #1;
            guard++;
        end
        bus.y_flat      = {y1, y0};
        bus.hand_valid  = hv;
        bus.frame_valid = 1'b1;
        last_acc        = cyc + 1;
        if (push) begin
            exp_tgt_q.push_back(tgt);
            exp_acc_q.push_back(last_acc);
            exp_name_q.push_back(name);
        end
        @(posedge clock);
        #1;
        bus.frame_valid = 1'b0;
        check({name, "_busy"}, bus.busy, 1);
    endtask

    initial begin
        int a, k0, k1;
        bus.on          = 1'b1;
        bus.frame_valid = 1'b0;
        bus.y_flat      = '0;
        bus.hand_valid  = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_target", bus.target, 0);
        check("rst_hover", bus.hover, 0);
        check("rst_track_lost", bus.track_lost, 0);
        reset = 1'b1;

        // Two-hand average, then the slew ramp from zero.
        send(16'd100, 16'd200, 2'b11, 8'd85, 1'b1, "avg");
        wait_idle("avg");
        wait_ticks(21);
        check("avg_hover_21", bus.hover, 84);
        wait_ticks(1);
        check("avg_hover_22", bus.hover, 85);
        wait_ticks(3);
        check("avg_hover_hold", bus.hover, 85);

        // Dead zone lands: hover steps down by 4 from 85.
        send(16'd100, 16'd400, 2'b11, 8'd0, 1'b1, "dead");
        wait_idle("dead");
        wait_ticks(1);
        check("dead_hover_1", bus.hover, 81);
        wait_ticks(1);
        check("dead_hover_2", bus.hover, 77);

        // Mapping corners: unusable hands, clamp, truncation, dead-zone edge.
        send(16'd40,  16'd0,   2'b11, 8'd128, 1'b1, "part_zero_y");   wait_idle("part_zero_y");
        send(16'd60,  16'd60,  2'b11, 8'd128, 1'b1, "clamp_130");     wait_idle("clamp_130");
        send(16'd48,  16'd52,  2'b11, 8'd128, 1'b1, "top_edge");      wait_idle("top_edge");
        send(16'd66,  16'd66,  2'b11, 8'd127, 1'b1, "map_127");       wait_idle("map_127");
        send(16'd101, 16'd102, 2'b11, 8'd110, 1'b1, "trunc");         wait_idle("trunc");
        send(16'd100, 16'd400, 2'b01, 8'd110, 1'b1, "hand0_only");    wait_idle("hand0_only");
        send(16'd400, 16'd100, 2'b10, 8'd110, 1'b1, "hand1_only");    wait_idle("hand1_only");
        send(16'd306, 16'd306, 2'b11, 8'd7,   1'b1, "dead_edge");     wait_idle("dead_edge");
        send(16'd307, 16'd307, 2'b11, 8'd0,   1'b1, "dead_over");     wait_idle("dead_over");
        send(16'd100, 16'd200, 2'b00, 8'd0,   1'b1, "none_valid");    wait_idle("none_valid");
        send(16'd0,   16'd0,   2'b11, 8'd0,   1'b1, "none_zero_y");   wait_idle("none_zero_y");

        // A second pulse while busy is dropped; only the first frame maps.
        send(16'd100, 16'd200, 2'b11, 8'd85, 1'b1, "hs_first");
        a = last_acc;
        wait_edge(a + 4);
        bus.y_flat      = {16'd60, 16'd60};
        bus.frame_valid = 1'b1;
        wait_edge(a + 5);
        bus.frame_valid = 1'b0;
        check("hs_still_busy", bus.busy, 1);
        wait_idle("hs_first");
        wait_edge(cyc + 30);

        // Dropping on forces hover to zero on the next edge and lands the target.
        wait_ticks(40);
        check("on_hover_before", bus.hover, 85);
        bus.on = 1'b0;
        @(posedge clock);
        #1;
        check("on_hover_drop", bus.hover, 0);
        send(16'd100, 16'd200, 2'b11, 8'd0, 1'b1, "off_frame");
        wait_idle("off_frame");
        wait_ticks(2);
        check("off_hover_held", bus.hover, 0);
        bus.on = 1'b1;

        // Tracking timeout ramps hover down; the next frame clears it.
        send(16'd100, 16'd200, 2'b11, 8'd85, 1'b1, "to_frame");
        a = last_acc;
        wait_idle("to_frame");
        wait_ticks(40);
        check("to_hover_up", bus.hover, 85);
        wait_edge(a + TIMEOUT - 1);
        check("to_not_yet", bus.track_lost, 0);
        wait_edge(a + TIMEOUT);
        check("to_lost", bus.track_lost, 1);
        wait_ticks(1);
        check("to_ramp_1", bus.hover, 81);
        wait_ticks(21);
        check("to_ramp_end", bus.hover, 0);
        check("to_target_kept", bus.target, 85);
        send(16'd60, 16'd60, 2'b11, 8'd128, 1'b1, "to_recover");
        check("to_lost_cleared", bus.track_lost, 0);
        k0 = tick_count;
        wait_idle("to_recover");
        k1 = tick_count - k0;
        wait_ticks(10);
        check("to_recover_hover", bus.hover, 4 * k1 + 40);

        // Reset in the middle of the divide aborts the frame.
        send(16'd100, 16'd200, 2'b11, 8'd0, 1'b0, "abort");
        a = last_acc;
        wait_edge(a + 9);
        reset = 1'b0;
        wait_edge(a + 10);
        check("abort_busy", bus.busy, 0);
        check("abort_target", bus.target, 0);
        check("abort_hover", bus.hover, 0);
        check("abort_lost", bus.track_lost, 0);
        reset = 1'b1;
        wait_edge(a + 50);
        check("abort_target_stays", bus.target, 0);
        send(16'd101, 16'd102, 2'b11, 8'd110, 1'b1, "post_reset");
        wait_idle("post_reset");
        wait_edge(cyc + 5);

        check("scoreboard_drained", exp_tgt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
